// File: rtl/delay_var.sv
// -----------------------------------------------------------------------------
// delay_var -- runtime-programmable delay line with valid tag and clock-enable.
//
// A sample accepted on enabled edge m is presented on source/source_valid right
// after enabled edge m+D, where D = clamp(delay_sel, 1, MAX_DELAY). Storage is a
// circular buffer of {valid, data} entries read at wr_ptr - D, followed by a
// registered output stage. Changing D flushes every in-flight valid bit so no
// stale sample can come out at the wrong latency; busy marks the refill window.
//
// Ports:
//   clk          clock
//   reset        synchronous reset, active-high
//   en           clock-enable; 0 freezes the whole block
//   delay_sel    requested delay (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   sink         input data
//   sink_valid   qualifies sink
//   source       delayed data (registered)
//   source_valid qualifies source (registered)
//   busy         high while the line refills after a delay change
//   range_err    sticky out-of-range delay_sel flag (only when the macro
//                DELAY_VAR_RANGE_ERR_EN is defined)
// -----------------------------------------------------------------------------
module delay_var #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DW-1:0]    delay_sel,
  input  logic [WIDTH-1:0] sink,
  input  logic             sink_valid,
  output logic [WIDTH-1:0] source,
  output logic             source_valid,
  output logic             busy
`ifdef DELAY_VAR_RANGE_ERR_EN
  ,
  output logic             range_err
`endif
);

  localparam int PW = $clog2(MAX_DELAY);

  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW:0]   MAX_D_X  = (DW+1)'(MAX_DELAY);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DELAY - 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  logic [WIDTH-1:0]     mem_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld_q, vld_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [DW:0]          rd_sum;
  logic [DW-1:0]        cur_delay_q, cur_delay_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        req_delay;
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     source_q, source_d;
  logic                 source_valid_q, source_valid_d;
  logic                 change;

  // NOTE: every variable written in an always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    req_delay = delay_sel;
    if (delay_sel == '0) begin
      req_delay = DW'(1);
    end else if (delay_sel > MAX_D) begin
      req_delay = MAX_D;
    end
  end

  // Aliases (0 vs 1, oversize vs MAX_DELAY) compare equal after clamping, so
  // they never count as a change.
  assign change = (req_delay != cur_delay_q);

  // Read address wr_ptr - D modulo MAX_DELAY. Adding MAX_DELAY first keeps the
  // sum non-negative; one conditional subtract wraps it. With D = MAX_DELAY the
  // read hits the slot about to be overwritten, returning its old contents.
  always_comb begin
    rd_sum = (DW+1)'(wr_ptr_q) + MAX_D_X - {1'b0, cur_delay_q};
    rd_ptr = (rd_sum >= MAX_D_X) ? PW'(rd_sum - MAX_D_X) : PW'(rd_sum);
  end

  always_comb begin
    wr_ptr_d       = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    // Flush first, then tag the sample of this edge with its own valid.
    vld_d          = change ? '0 : vld_q;
    vld_d[wr_ptr_q] = sink_valid;
    source_d       = mem_q[rd_ptr];
    source_valid_d = change ? 1'b0 : vld_q[rd_ptr];
  end

  // Refill tracking: after a change to D the first fresh sample needs D edges,
  // busy covers the first D-1 of them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_delay_d = cur_delay_q;
    if (change) begin
      cur_delay_d = req_delay;
      cnt_d       = req_delay - DW'(1);
      state_d     = (req_delay > DW'(1)) ? ST_SETTLE : ST_RUN;
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q - DW'(1);
      if (cnt_q == DW'(1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q          <= '0;
      wr_ptr_q       <= '0;
      cur_delay_q    <= req_delay;
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      source_q       <= '0;
      source_valid_q <= 1'b0;
    end else if (en) begin
      vld_q          <= vld_d;
      wr_ptr_q       <= wr_ptr_d;
      cur_delay_q    <= cur_delay_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      source_q       <= source_d;
      source_valid_q <= source_valid_d;
    end
  end

  // NOTE: the data array is not reset; its contents are only observed through
  // the valid bits, which are, so the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[wr_ptr_q] <= sink;
    end
  end

  assign source       = source_q;
  assign source_valid = source_valid_q;
  assign busy         = (state_q == ST_SETTLE);

`ifdef DELAY_VAR_RANGE_ERR_EN
  logic range_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      range_err_q <= 1'b0;
    end else if (en && ((delay_sel == '0) || (delay_sel > MAX_D))) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`endif

endmodule

// File: doc/delay_var.md
Name: delay_var

Overview:
- Runtime-programmable delay line with a per-sample valid tag and a pipeline clock-enable (stall).
- Delay is selectable from 1 to MAX_DELAY clock-enabled cycles via `delay_sel`.
- A change of delay flushes stale in-flight samples, so no sample is ever emitted at the wrong latency.
- Sits in datapaths that must realign streams whose relative latency is only known at run time, e.g. after configurable filter stages.

Parameters:
- WIDTH, 8, data bus width in bits, ≥1.
- MAX_DELAY, 16, largest supported delay in enabled cycles, ≥2.
- DW (localparam), $clog2(MAX_DELAY+1), width of `delay_sel`.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- en  input  1  clock-enable; 0 = whole block holds state
- delay_sel  input  DW  requested delay; 0 treated as 1; values >MAX_DELAY clamped to MAX_DELAY
- sink  input  WIDTH  input data
- sink_valid  input  1  qualifies `sink`; sampled only when en=1
- source  output  WIDTH  delayed data (registered)
- source_valid  output  1  qualifies `source` (registered)
- busy  output  1  high while the pipeline refills after a delay change

Behaviour:
- Effective delay D = clamp(delay_sel, 1, MAX_DELAY), held in internal register `cur_delay`.
- Storage: circular buffer of MAX_DELAY entries {valid, data}, one write pointer, read pointer = wr_ptr − cur_delay mod MAX_DELAY, plus a registered output stage. Any equivalent structure meeting the timing below is acceptable.
- Latency: a sample accepted at enabled edge m appears on `source`/`source_valid` immediately after enabled edge m+D.
  - D=1 is the plain 1-cycle register case.
  - Disabled edges (en=0) do not count toward latency.
- `en`=0:
  - Buffer, pointers, cur_delay, FSM, counter, `source`, `source_valid` and `busy` all hold.
  - `sink`, `sink_valid` and `delay_sel` are ignored.
- `sink_valid`=0 on an enabled edge still advances the line; it emits a bubble with `source_valid`=0 D cycles later. `source` data for bubbles is unspecified; the bench checks data only when valid.
- Reset (any cycle, including mid-stream or during SETTLE):
  - `source`=0, `source_valid`=0, `busy`=0.
  - All buffer valid bits cleared; wr_ptr=0.
  - cur_delay loaded with clamp(delay_sel); FSM=RUN; counter=0.
  - Buffer data need not be cleared.
- FSM states:
  - RUN: normal operation, busy=0.
  - SETTLE: busy=1.
- Delay change: on an enabled edge k where clamp(delay_sel) ≠ cur_delay:
  - cur_delay ← new D.
  - All buffer valid bits are cleared in the same edge, then the sample at edge k is written with its own valid.
  - `source_valid` at edge k ← 0.
  - counter ← D−1; FSM → SETTLE if D>1, else stays RUN.
- SETTLE: counter decrements on each enabled edge; → RUN on the edge where counter reaches 0. `source_valid` is never 1 for samples accepted before edge k.
- A further delay change during SETTLE restarts the sequence: flush again, reload counter with the newest D−1.
- Same-value `delay_sel` writes (including the 0→1 and >MAX_DELAY→MAX_DELAY aliases) are not changes: no flush.
- Pointer wrap: wr_ptr increments modulo MAX_DELAY. Read address is computed modulo MAX_DELAY with no off-by-one at wrap, for every D.

Optional Feature:
- Macro: DELAY_VAR_RANGE_ERR_EN.
- Defined:
  - Extra output port `range_err` (1 bit).
  - `range_err` is set sticky on any enabled edge where delay_sel=0 or delay_sel>MAX_DELAY; cleared only by reset.
  - Clamping still applies.
- Undefined:
  - Port absent; out-of-range values are clamped silently.
  - No other behavioural difference.

Test Plan:
- Fixed delay, en=1: MAX_DELAY=16, delay_sel=5, counter stream 0x00..0x3F with sink_valid=1 → each value appears exactly 5 edges after entry; source_valid=0 for the first 5 edges after reset; check across ≥4 pointer wraps.
- Stall: delay_sel=4, en toggled 1,0,0,1,1,0,1… → outputs hold during en=0; each sample appears after exactly 4 enabled edges; no sample lost or duplicated.
- Delay change: run D=8 with stream, switch delay_sel to 3 at edge k → busy=1 for 2 enabled edges; no pre-k sample ever valid; sample at k appears at edge k+3.
- Change during SETTLE: D 2→12, then →6 after 4 cycles → counter restarts at 5; first valid output is the sample at the second change edge, after 6 edges.
- Bounds: delay_sel=0 → delay 1; delay_sel=31 (DW=5) → delay 16; with DELAY_VAR_RANGE_ERR_EN, range_err=1 and stays 1 until reset.
- Reset mid-operation during SETTLE with valid data in flight → next cycle source=0, source_valid=0, busy=0; no pre-reset sample emerges.
